hd_stream_accumulator: RTL

Sequential accumulation stage that sits directly downstream of `N_bit_adder`. It consumes a valid/ready stream of WIDTH-bit unsigned operands and folds each beat into a running ACC_WIDTH-bit sum. The fold uses an internal `N_bit_adder #(ACC_WIDTH)` instance. When the beat tagged `in_last` is accepted, the block presents the completed sum, a beat count and a sticky overflow flag on a held output handshake. It forms the bundling/summation step of the HD datapath.

---
 rtl/hd_stream_accumulator.sv | 99 +++++++++
 1 files changed

// File: rtl/hd_stream_accumulator.sv
// Bundling stage of the HD datapath: folds a valid/ready operand stream into a
// running sum and presents sum, beat count and sticky wrap flag once per bundle.

// Ripple-carry adder, result modulo 2^N; no carry-out is exposed.
module N_bit_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic [N-1:0] c;

  assign c[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
    if (gi < N - 1) begin : g_carry
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  end
endmodule

module hd_stream_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;
  } acc_st_t;

  state_t               state_q, state_d;
  acc_st_t              st_q;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 accept;
  logic                 drain;

  assign in_ready  = (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign in_ext    = ACC_WIDTH'(in_data);

  N_bit_adder #(.N(ACC_WIDTH)) u_add (
    .a   (st_q.acc),
    .b   (in_ext),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: if (accept) state_d = in_last ? S_DONE : S_ACCUM;
      S_DONE:          if (drain)  state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Wrap is detected by the result dropping below the old sum, since the adder
  // has no carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (drain) begin
      st_q <= '0;
    end else if (accept) begin
      st_q.acc <= add_sum;
      st_q.cnt <= (&st_q.cnt) ? st_q.cnt : st_q.cnt + CNT_WIDTH'(1);
      st_q.ovf <= st_q.ovf | (add_sum < st_q.acc);
    end
  end

  assign out_sum      = st_q.acc;
  assign out_count    = st_q.cnt;
  assign out_overflow = st_q.ovf;
endmodule
